// File: rtl/bobc_pkg.sv
// Shared encodings for the bloco_operativo datapath: operand/coefficient
// select codes and the serial multiplier state codes.
package bobc_pkg;

  localparam logic [1:0] M0_ZERO = 2'b00;
  localparam logic [1:0] M0_RX   = 2'b01;
  localparam logic [1:0] M0_RH   = 2'b10;
  localparam logic [1:0] M0_RS   = 2'b11;

  localparam logic [1:0] M1_ZERO = 2'b00;
  localparam logic [1:0] M1_RX   = 2'b01;
  localparam logic [1:0] M1_RH   = 2'b10;
  localparam logic [1:0] M1_ONE  = 2'b11;

  localparam logic [1:0] M2_NONE = 2'b00;
  localparam logic [1:0] M2_C1   = 2'b01;
  localparam logic [1:0] M2_C2   = 2'b10;
  localparam logic [1:0] M2_C3   = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mult_serial.sv
// W-bit sequential shift-add multiplier. Operands are latched on start;
// the product (mod 2^W) is held with pronto=1 until acknowledged or aborted.
module mult_serial
  import bobc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic         i_ack,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_pronto,
  output logic [W-1:0] o_p
);

  localparam int CW = $clog2(W + 1);

  mul_state_t    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_pronto;

  // W shift-add steps, then one extra edge to publish the product: launch to pronto = W+1.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_state  <= MUL_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_pronto <= 1'b0;
    end else if (i_abort) begin
      r_state  <= MUL_IDLE;
      r_pronto <= 1'b0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (r_cnt == CW'(W)) begin
            r_state  <= MUL_DONE;
            r_pronto <= 1'b1;
          end else begin
            if (r_b[0]) begin
              r_acc <= r_acc + r_a;
            end
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        MUL_DONE: begin
          if (i_ack) begin
            r_state  <= MUL_IDLE;
            r_pronto <= 1'b0;
          end
        end
        default: begin
          r_state  <= MUL_IDLE;
          r_pronto <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = (r_state == MUL_BUSY);
  assign o_pronto = r_pronto;
  assign o_p      = r_acc;

endmodule

// File: rtl/bloco_operativo.sv
// Operative block: RX/RH/RS registers, operand muxes, adder and a serial
// multiplier, driven by the sequencing FSM's load/select controls.
module bloco_operativo
  import bobc_pkg::*;
#(
  parameter int W  = 8,
  parameter int C1 = 3,
  parameter int C2 = 5,
  parameter int C3 = 7
) (
  input  logic         ck,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic         lx,
  input  logic [1:0]   m0,
  input  logic [1:0]   m1,
  input  logic [1:0]   m2,
  input  logic         h,
  input  logic         lh,
  input  logic         ls,
  output logic         pronto,
  output logic         erro,
  output logic [W-1:0] s
);

  logic [W-1:0] r_rx;
  logic [W-1:0] r_rh;
  logic [W-1:0] r_rs;
  logic         r_erro;

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_coef;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_p;
  logic         w_pronto;
  logic         w_busy;
  logic         w_start;

  always_comb begin
    w_a = '0;
    case (m0)
      M0_ZERO: w_a = '0;
      M0_RX:   w_a = r_rx;
      M0_RH:   w_a = r_rh;
      M0_RS:   w_a = r_rs;
      default: w_a = '0;
    endcase
  end

  always_comb begin
    w_b = '0;
    case (m1)
      M1_ZERO: w_b = '0;
      M1_RX:   w_b = r_rx;
      M1_RH:   w_b = r_rh;
      M1_ONE:  w_b = W'(1);
      default: w_b = '0;
    endcase
  end

  always_comb begin
    w_coef = '0;
    case (m2)
      M2_NONE: w_coef = '0;
      M2_C1:   w_coef = W'(C1);
      M2_C2:   w_coef = W'(C2);
      M2_C3:   w_coef = W'(C3);
      default: w_coef = '0;
    endcase
  end

  assign w_sum = w_a + w_b;

  // The multiplier only accepts start while idle; the extra qualification keeps launches explicit here.
  assign w_start = !h && (m2 != M2_NONE) && !w_busy && !w_pronto;

  mult_serial #(
    .W(W)
  ) u_mult (
    .ck      (ck),
    .rst     (rst),
    .i_start (w_start),
    .i_abort (h),
    .i_ack   (lh && !h),
    .i_a     (w_a),
    .i_b     (w_coef),
    .o_busy  (w_busy),
    .o_pronto(w_pronto),
    .o_p     (w_p)
  );

  // ls captures the RH value from before this edge, so lh and ls may coincide.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_rx   <= '0;
      r_rh   <= '0;
      r_rs   <= '0;
      r_erro <= 1'b0;
    end else begin
      if (lx) begin
        r_rx <= x;
      end
      if (ls) begin
        r_rs <= r_rh;
      end
      if (lh) begin
        if (h) begin
          r_rh <= w_sum;
        end else if (w_pronto) begin
          r_rh <= w_p;
        end else begin
          r_erro <= 1'b1;
        end
      end
    end
  end

  assign pronto = w_pronto;
  assign erro   = r_erro;
  assign s      = r_rs;

endmodule
